// File: rtl/prog_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prog_rom_arbiter_pkg
//   Shared definitions for the program ROM arbiter:
//     - default address / data widths of the program bus
//     - default starvation limit and starvation counter width
//     - owner_e : who owns the ROM data in the cycle after a grant
// -----------------------------------------------------------------------------
package prog_rom_arbiter_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/prog_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// prog_rom_arbiter_if
//   One requester-side read channel of the program ROM arbiter.
//   Signals:
//     req    : read request, held with addr stable until gnt
//     addr   : read address
//     gnt    : request accepted this cycle (combinational from the arbiter)
//     rvalid : rdata valid, one cycle after gnt
//     rdata  : read data
//   Modports:
//     master : the requester (CPU fetch or debug/loader port)
//     slave  : the arbiter
// -----------------------------------------------------------------------------
interface prog_rom_arbiter_if
    import prog_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/prog_rom_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// prog_rom_arbiter_sat_counter
//   Saturating up-counter used to track how many consecutive cycles the debug
//   requester has lost arbitration.
//   Ports:
//     i_clk      : clock
//     i_reset    : synchronous active-high reset, clears the count
//     i_inc      : increment by one, saturating at LIMIT
//     i_clr      : clear to zero (wins over i_inc)
//     o_at_limit : count equals LIMIT
// -----------------------------------------------------------------------------
module prog_rom_arbiter_sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (v >= LIMIT_V) begin
            res = LIMIT_V;
        end else begin
            res = v + WIDTH'(1);
        end
        return res;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_at_limit = (r_count == LIMIT_V);

endmodule

// File: rtl/prog_rom_arbiter.sv
// -----------------------------------------------------------------------------
// prog_rom_arbiter
//   Shares the single combinational program ROM port between the RV32E
//   instruction fetch (CPU, fixed priority) and a debug/loader read port (DBG).
//   DBG is forced through after MAX_WAIT consecutive lost cycles. One grant per
//   cycle; read data is returned one cycle after the grant.
//   Ports:
//     i_clk      : system clock
//     i_reset    : synchronous active-high reset
//     cpu_bus    : CPU read channel (slave side)
//     dbg_bus    : DBG read channel (slave side)
//     o_rom_addr : registered ROM address, holds its value while idle
//     i_rom_data : ROM data, combinational function of o_rom_addr
// -----------------------------------------------------------------------------
module prog_rom_arbiter
    import prog_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    prog_rom_arbiter_if.slave cpu_bus,
    prog_rom_arbiter_if.slave dbg_bus,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data
);

    owner_e            r_owner_p1;
    owner_e            w_owner_nxt;
    logic [ADDR_W-1:0] r_rom_addr_p1;
    logic              w_force_dbg;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_cnt_inc;
    logic              w_cnt_clr;

    // ---- stage p0: arbitration (combinational, cycle N) ----
    // DBG wins when the CPU is idle or when it has been starved long enough;
    // grants are suppressed entirely while reset is high.
    assign w_dbg_gnt = !i_reset && dbg_bus.req && (w_force_dbg || !cpu_bus.req);
    assign w_cpu_gnt = !i_reset && cpu_bus.req && !w_dbg_gnt;

    assign cpu_bus.gnt = w_cpu_gnt;
    assign dbg_bus.gnt = w_dbg_gnt;

    // Count a loss only when DBG was actually waiting behind a CPU grant; any
    // cycle where DBG is served or not asking restarts the count.
    assign w_cnt_inc = w_cpu_gnt && dbg_bus.req;
    assign w_cnt_clr = w_dbg_gnt || !dbg_bus.req;

    prog_rom_arbiter_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_inc      (w_cnt_inc),
        .i_clr      (w_cnt_clr),
        .o_at_limit (w_force_dbg)
    );

    // Owner next-state: who the ROM data belongs to in cycle N+1.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_cpu_gnt) begin
            w_owner_nxt = OWN_CPU;
        end else if (w_dbg_gnt) begin
            w_owner_nxt = OWN_DBG;
        end
    end

    // ---- stage p1: registered address and owner (cycle N+1) ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner_p1 <= OWN_NONE;
        end else begin
            r_owner_p1 <= w_owner_nxt;
        end
    end

    // The address bus only moves on a grant so the ROM sees no toggling when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr_p1 <= '0;
        end else if (w_cpu_gnt) begin
            r_rom_addr_p1 <= cpu_bus.addr;
        end else if (w_dbg_gnt) begin
            r_rom_addr_p1 <= dbg_bus.addr;
        end
    end

    assign o_rom_addr = r_rom_addr_p1;

    // rvalid is masked during reset so a grant issued just before reset
    // asserts never surfaces as valid data.
    assign cpu_bus.rvalid = (r_owner_p1 == OWN_CPU) && !i_reset;
    assign dbg_bus.rvalid = (r_owner_p1 == OWN_DBG) && !i_reset;

    assign cpu_bus.rdata = i_rom_data;
    assign dbg_bus.rdata = i_rom_data;

endmodule

// File: doc/prog_rom_arbiter.md
Name: prog_rom_arbiter

Overview:
- Shares the single combinational program ROM port (32-bit address in, 32-bit data out) between two requesters: the RV32E core instruction fetch (CPU) and a debug/loader read port (DBG).
- Sits between rv32e_soc and program_rom, on the program address/data buses.
- CPU has fixed priority. A starvation counter guarantees DBG a grant after MAX_WAIT consecutive lost cycles.
- Pipelined: one grant per cycle, read data one cycle after grant.

Parameters:
- ADDR_W, 32, address width of requesters and ROM
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive DBG losses that force a DBG grant (1..15)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU read request; held with cpu_addr stable until cpu_gnt
- cpu_addr  in  ADDR_W  CPU read address
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (registered)
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  DBG read request; same hold rule
- dbg_addr  in  ADDR_W  DBG read address
- dbg_gnt  out  1  DBG request accepted this cycle (combinational)
- dbg_rvalid  out  1  dbg_rdata valid (registered)
- dbg_rdata  out  DATA_W  DBG read data
- rom_addr  out  ADDR_W  to ROM address bus (registered)
- rom_data  in  DATA_W  from ROM data bus (combinational function of rom_addr)

Behaviour:
- Reset (synchronous, active-high):
  - rom_addr=0, cpu_rvalid=0, dbg_rvalid=0, wait_cnt=0, owner=NONE.
  - cpu_gnt and dbg_gnt forced 0 while reset is high.
  - Any grant issued in the cycle before reset asserts produces no rvalid.
- Arbitration (combinational, cycle N):
  - force_dbg = (wait_cnt == MAX_WAIT).
  - Grant DBG if dbg_req and (force_dbg or !cpu_req).
  - Otherwise grant CPU if cpu_req.
  - At most one gnt high per cycle.
- Starvation counter wait_cnt (4 bits), updated at the end of N:
  - cpu_gnt && dbg_req → wait_cnt+1, saturating at MAX_WAIT.
  - dbg_gnt or !dbg_req → clear to 0.
- Address path, at the end of N:
  - On a grant, rom_addr <= granted address.
  - With no grant, rom_addr holds its previous value (no bus toggling when idle).
- Owner FSM, states NONE, CPU, DBG; next state set at the end of N:
  - CPU if cpu_gnt, DBG if dbg_gnt, else NONE.
  - The state names who owns the ROM data in cycle N+1.
- Return path, cycle N+1:
  - cpu_rvalid = (owner==CPU), dbg_rvalid = (owner==DBG); both registered.
  - cpu_rdata and dbg_rdata are both driven from rom_data.
  - Data is meaningful only while the matching rvalid is high.
- Latency: grant in N → rvalid and data in N+1. Back-to-back grants every cycle, full throughput.
- Simultaneous requests:
  - CPU wins unless force_dbg.
  - When force_dbg is set, DBG wins exactly one cycle and CPU gets gnt=0 for that cycle.
- A requester whose req is not granted must keep req and addr stable. The arbiter keeps no request queue.
- With MAX_WAIT contention, CPU loses at most 1 in MAX_WAIT+1 cycles.
- Widths: addresses and data pass through unmodified; no arithmetic on the address.

Decomposition:
- Shared package (rv32e_pkg):
  - owner state encoding: NONE=2'd0, CPU=2'd1, DBG=2'd2
  - default ADDR_W/DATA_W constants
- No sub-module needed. The arbiter is a small FSM plus counter in one module. The starvation counter may optionally be the sub-module sat_counter (width, limit parameters, inc/clr inputs, at_limit output).

Test Plan:
- Only CPU requests 0x00,0x04,0x08 on consecutive cycles → cpu_gnt=1 each cycle; rom_addr follows one cycle later; cpu_rvalid=1 with rdata = ROM[0x00],[0x04],[0x08] in cycles 2-4; dbg_* stay 0.
- Only DBG requests 0x40, CPU idle → dbg_gnt=1 same cycle; dbg_rvalid=1 with ROM[0x40] next cycle; wait_cnt stays 0.
- CPU requests continuously, DBG holds req at 0x80, MAX_WAIT=4 → CPU granted 4 cycles, then dbg_gnt=1 and cpu_gnt=0 in cycle 5, dbg_rvalid with ROM[0x80] in cycle 6, wait_cnt back to 0; pattern repeats every 5 cycles.
- Idle after a grant to 0x10 → rom_addr holds 0x10; both rvalid=0 from the following cycle.
- Reset asserted in the cycle after a CPU grant → cpu_rvalid=0 in the next cycle; rom_addr=0, wait_cnt=0, gnts 0 while reset high; normal grant resumes the first cycle after reset deasserts.
- Simultaneous CPU and DBG requests with wait_cnt=0 → CPU granted, wait_cnt=1; DBG drops req the next cycle → wait_cnt cleared to 0.
